// File: rtl/dmem_rom_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of the combinational image-data ROM.
// Optional request/conflict statistics counters: define DMEM_ROM_ARBITER_STATS_EN.
module dmem_rom_arbiter #(
   parameter int unsigned S    = 32,
   parameter int unsigned V    = 192,
   parameter int unsigned SIZE = 30000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [S-1:0] req0_addr,
   input  logic         req0_is_vector,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [S-1:0] req1_addr,
   input  logic         req1_is_vector,
   output logic         rsp0_valid,
   input  logic         rsp0_ready,
   output logic         rsp1_valid,
   input  logic         rsp1_ready,
   output logic [V-1:0] rsp_data,
   output logic         rsp_err,
   output logic [S-1:0] mem_addr,
   output logic         mem_is_vector,
`ifdef DMEM_ROM_ARBITER_STATS_EN
   output logic [31:0]  grant_cnt0,
   output logic [31:0]  grant_cnt1,
   output logic [31:0]  conflict_cnt,
`endif
   input  logic [V-1:0] mem_rd
);

   localparam int unsigned AW = S + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t         state, state_nxt;
   logic           last_grant;
   logic           win;
   logic [S-1:0]   lat_addr;
   logic           lat_vec;
   logic           pick;
   logic           accept;
   logic [AW-1:0]  end_addr;
   logic           range_err;
   logic [V-1:0]   data_nxt;

   // Both valid: the port not granted last wins; otherwise the only valid one.
   assign pick = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

   // Extra address bit keeps the last-word computation from wrapping.
   assign end_addr  = AW'(lat_addr) + (lat_vec ? AW'(5) : AW'(0));
   assign range_err = end_addr > AW'(SIZE - 1);

   always_comb begin
      data_nxt = '0;
      if (!range_err) begin
         data_nxt = lat_vec ? mem_rd : V'(mem_rd[S-1:0]);
      end
   end

   always_comb begin
      state_nxt     = state;
      accept        = 1'b0;
      req0_ready    = 1'b0;
      req1_ready    = 1'b0;
      mem_addr      = '0;
      mem_is_vector = 1'b0;
      rsp0_valid    = 1'b0;
      rsp1_valid    = 1'b0;
      case (state)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               accept     = 1'b1;
               req0_ready = ~pick;
               req1_ready = pick;
               state_nxt  = ISSUE;
            end
         end
         ISSUE: begin
            mem_addr      = lat_addr;
            mem_is_vector = lat_vec;
            state_nxt     = RESP;
         end
         RESP: begin
            rsp0_valid = ~win;
            rsp1_valid = win;
            if (win ? rsp1_ready : rsp0_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         win        <= 1'b0;
         lat_addr   <= '0;
         lat_vec    <= 1'b0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            win        <= pick;
            last_grant <= pick;
            lat_addr   <= pick ? req1_addr : req0_addr;
            lat_vec    <= pick ? req1_is_vector : req0_is_vector;
         end
         if (state == ISSUE) begin
            rsp_data <= data_nxt;
            rsp_err  <= range_err;
         end
      end
   end

`ifdef DMEM_ROM_ARBITER_STATS_EN
   // Saturating grant and conflict counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt0   <= '0;
         grant_cnt1   <= '0;
         conflict_cnt <= '0;
      end else begin
         if (accept && !pick && grant_cnt0 != '1) begin
            grant_cnt0 <= grant_cnt0 + 32'd1;
         end
         if (accept && pick && grant_cnt1 != '1) begin
            grant_cnt1 <= grant_cnt1 + 32'd1;
         end
         if (state == IDLE && req0_valid && req1_valid && conflict_cnt != '1) begin
            conflict_cnt <= conflict_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
